// File: rtl/cdb_req_buf.sv
// rtl/cdb_req_buf.sv - CDB request buffer: in-order result FIFO between a functional unit and the CDB arbiter (option: CDB_REQ_BUF_BYPASS_EN)
module cdb_req_buf #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [DATA_W-1:0]        in_wdata,
  output logic                     cdb_req,
  input  logic                     cdb_rdy,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_wdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic byp;
  logic wr_en;

  // Handshake decode; rst_n gates the outputs so they drop as soon as reset asserts.
  always_comb begin
    empty  = (count == '0);
    full   = (count == FULL_CNT);
    in_rdy = rst_n && !full && !flush;
    push   = in_vld && in_rdy;
    byp    = 1'b0;
`ifdef CDB_REQ_BUF_BYPASS_EN
    byp    = rst_n && empty && in_vld && !flush;
`endif
    cdb_req = rst_n && !flush && (!empty || byp);
    // A bypassed result granted in the same cycle never touches storage.
    pop    = !empty && cdb_req && cdb_rdy;
    wr_en  = push && !(byp && cdb_rdy);
    cdb_tag   = '0;
    cdb_wdata = '0;
`ifdef CDB_REQ_BUF_BYPASS_EN
    if (byp) begin
      cdb_tag   = in_tag;
      cdb_wdata = in_wdata;
    end else if (cdb_req) begin
      cdb_tag   = tag_mem[rd_ptr];
      cdb_wdata = data_mem[rd_ptr];
    end
`else
    if (cdb_req) begin
      cdb_tag   = tag_mem[rd_ptr];
      cdb_wdata = data_mem[rd_ptr];
    end
`endif
  end

  // Pointer and occupancy state; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless outside the occupied window, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_ptr]  <= in_tag;
      data_mem[wr_ptr] <= in_wdata;
    end
  end

endmodule

// File: doc/cdb_req_buf.md
CDB_REQ_BUF -- requirements
Module: cdb_req_buf

Interface
REQ-001 SHALL have parameter TAG_W, default 4: width of the ROB/RS tag carried with each result.
REQ-002 SHALL have parameter DATA_W, default 32: result data width.
REQ-003 SHALL have parameter DEPTH, default 4: buffer entries; a power of two, at least 2.
REQ-004 SHALL have port clk  in  1: sole clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port flush  in  1: discard all buffered results, e.g. on mispredict.
REQ-007 SHALL have port in_vld  in  1: functional unit presents a completed result.
REQ-008 SHALL have port in_rdy  out  1: buffer accepts the presented result this cycle.
REQ-009 SHALL have port in_tag  in  TAG_W: destination tag of the presented result.
REQ-010 SHALL have port in_wdata  in  DATA_W: presented result value.
REQ-011 SHALL have port cdb_req  out  1: request to the CDB arbiter (exu2cdb req).
REQ-012 SHALL have port cdb_rdy  in  1: arbiter grant (exu2cdb rdy); may depend combinationally on cdb_req.
REQ-013 SHALL have port cdb_tag  out  TAG_W: tag of the head entry (exu2cdb tag).
REQ-014 SHALL have port cdb_wdata  out  DATA_W: data of the head entry (exu2cdb wdata).
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1: current number of occupied entries.

Function
REQ-016 SHALL implement a circular FIFO with read and write pointers that wrap from DEPTH-1 to 0.
REQ-017 SHALL push on in_vld && in_rdy and pop on cdb_req && cdb_rdy.
REQ-018 SHALL drive in_rdy = (count != DEPTH) && !flush, with no combinational path from cdb_rdy.
REQ-019 SHALL drive cdb_req = (count != 0) && !flush, and drive cdb_tag/cdb_wdata from the head entry.
REQ-020 SHALL hold cdb_req, cdb_tag and cdb_wdata stable while cdb_req && !cdb_rdy; ungranted results are never dropped or reordered.
REQ-021 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers; this covers the full case only when full was reached earlier.
REQ-022 SHALL deliver results to the CDB in strict arrival order.
REQ-023 SHALL, on flush high at a clock edge, set count and both pointers to 0, ignoring any same-cycle push or pop; entry storage contents are don't-care.
REQ-024 SHALL, without bypass, have a latency of exactly 1 cycle from the accepting edge to cdb_req high when empty.
REQ-025 SHALL drive cdb_tag/cdb_wdata as '0 when cdb_req is low.
REQ-026 SHALL never underflow or overflow count, including under continuous in_vld with cdb_rdy held low.

Reset
REQ-027 SHALL, while rst_n is low, force count, the pointers, cdb_req and in_rdy to 0, asynchronously and independent of clk.
REQ-028 SHALL discard any in-flight result on reset mid-operation, with no CDB request issued for it after release.
REQ-029 SHALL set in_rdy to 1 on the first cycle after rst_n deasserts, with cdb_req at 0.

Configuration
REQ-030 SHALL provide macro CDB_REQ_BUF_BYPASS_EN as the single compile-time option.
REQ-031 SHALL, with CDB_REQ_BUF_BYPASS_EN defined, assert cdb_req in the same cycle when the buffer is empty, in_vld is high and flush is low, driving cdb_tag/cdb_wdata from in_tag/in_wdata.
REQ-032 SHALL, in that bypass case, not write the result if cdb_rdy is high, and push it as the head entry if cdb_rdy is low.
REQ-033 SHALL, without the macro, always use the registered 1-cycle path of REQ-024, with no combinational in_* to cdb_* path.

Verification
REQ-034 SHALL cover single result: in_tag=3, in_wdata=0xDEADBEEF for 1 cycle, cdb_rdy=1 -> next cycle cdb_req=1, tag 3, data 0xDEADBEEF; then count=0 (no bypass).
REQ-035 SHALL cover backpressure: push tags 1,2,3,4 with cdb_rdy=0 -> count=4, in_rdy=0, cdb_tag=1 stable; then cdb_rdy=1 -> tags 1,2,3,4 on 4 consecutive cycles.
REQ-036 SHALL cover wrap-around: 10 results with cdb_rdy toggling 1,0,1,0... -> all 10 tags emerge in order, count never exceeds 4.
REQ-037 SHALL cover flush: with count=3, flush=1 plus in_vld=1 in the same cycle -> next cycle count=0, cdb_req=0, and the flushed tag never appears.
REQ-038 SHALL cover reset: rst_n low mid-burst with count=2 -> count=0 and cdb_req=0 immediately; after release, in_rdy=1 and no stale requests.
REQ-039 SHALL cover bypass (macro defined): empty buffer, in_vld with tag 5, cdb_rdy=1 -> cdb_req=1 with tag 5 in the same cycle, count stays 0.
